lsu_req_arbiter: RTL and testbench

//  Shares the single header LSU between NUM_REQ requesters (malloc FSM, free FSM, ...).

---
 rtl/allocator_pkg.sv | 41 ++++
 rtl/lsu_req_arbiter_rr.sv | 33 +++
 rtl/lsu_req_arbiter.sv | 127 ++++++++++++
 tb/tb_lsu_req_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/allocator_pkg.sv
// Shared types for the allocator header-LSU path.
// Request/response bundles and the LSU arbiter state encoding.
package allocator_pkg;

   localparam int NUM_LSU_REQ = 2;

   typedef enum logic [3:0] {
      LSU_LOAD,
      LSU_STORE,
      LSU_INSERT,
      LSU_REMOVE,
      LSU_LOCK,
      LSU_UNLOCK
   } lsu_op_e;

   // 225 bits
   typedef struct packed {
      logic        val;
      lsu_op_e     lsu_op;
      logic [63:0] addr;
      logic [63:0] size;
      logic [63:0] next_addr;
      logic [27:0] tag;
   } header_data_req_t;

   // 193 bits
   typedef struct packed {
      logic        val;
      logic [63:0] addr;
      logic [63:0] size;
      logic [63:0] next_addr;
   } header_data_rsp_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT_RSP,
      ARB_LOCKED
   } lsu_arb_state_e;

endpackage

// File: rtl/lsu_req_arbiter_rr.sv
// Combinational round-robin picker.
// Searches valid[] starting at ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   always_comb begin
      int j;
      j       = 0;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      // lowest offset from ptr wins, so scan offsets downward
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (valid[j[IW-1:0]]) begin
            gnt              = '0;
            gnt[j[IW-1:0]]   = 1'b1;
            gnt_idx          = j[IW-1:0];
            any              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lsu_req_arbiter.sv
// Shares the header LSU between several requesters.
// Round-robin, one op in flight, LOCK/UNLOCK give exclusive ownership.
module lsu_req_arbiter
   import allocator_pkg::*;
#(
   parameter int NUM_REQ = NUM_LSU_REQ
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  header_data_req_t           req_i [NUM_REQ],
   output logic [NUM_REQ-1:0]         req_ready_o,
   output header_data_rsp_t           rsp_o [NUM_REQ],
   output header_data_req_t           lsu_req_o,
   input  logic                       lsu_ready_i,
   input  header_data_rsp_t           lsu_rsp_i,
   output logic                       locked_o,
   output logic [$clog2(NUM_REQ)-1:0] owner_o
);

   localparam int IW = $clog2(NUM_REQ);

   lsu_arb_state_e   state_q, state_d;
   header_data_req_t req_q, req_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    gnt_idx, owner_inc;
   logic             lock_q, lock_d;
   logic             any;
   logic [NUM_REQ-1:0] valid, gnt;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) valid[k] = req_i[k].val;
   end

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .valid   (valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   assign owner_inc = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      lock_d      = lock_q;
      req_ready_o = '0;
      lsu_req_o   = '0;
      for (int k = 0; k < NUM_REQ; k++) rsp_o[k] = '0;
      unique case (state_q)
         ARB_IDLE: begin
            req_ready_o = gnt;
            if (any) begin
               req_d   = req_i[gnt_idx];
               owner_d = gnt_idx;
               state_d = ARB_ISSUE;
            end
         end
         ARB_LOCKED: begin
            req_ready_o[owner_q] = 1'b1;
            if (req_i[owner_q].val) begin
               req_d   = req_i[owner_q];
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            lsu_req_o     = req_q;
            lsu_req_o.val = 1'b1;
            if (lsu_ready_i) state_d = ARB_WAIT_RSP;
         end
         ARB_WAIT_RSP: begin
            if (lsu_rsp_i.val) begin
               rsp_o[owner_q] = lsu_rsp_i;
               unique case (req_q.lsu_op)
                  LSU_LOCK: begin
                     lock_d  = 1'b1;
                     state_d = ARB_LOCKED;
                  end
                  LSU_UNLOCK: begin
                     lock_d  = 1'b0;
                     state_d = ARB_IDLE;
                     ptr_d   = owner_inc;
                  end
                  default: begin
                     if (lock_q) begin
                        state_d = ARB_LOCKED;
                     end else begin
                        state_d = ARB_IDLE;
                        ptr_d   = owner_inc;
                     end
                  end
               endcase
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      // no grants may leak out while reset holds the FSM
      if (!rst_ni) req_ready_o = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         req_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

   assign locked_o = lock_q;
   assign owner_o  = owner_q;

endmodule

// File: tb/tb_lsu_req_arbiter.sv
// Bench for lsu_req_arbiter: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_lsu_req_arbiter;
   import allocator_pkg::*;

   localparam int N = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   header_data_req_t req [N];
   logic [N-1:0]     ready;
   header_data_rsp_t rsp [N];
   header_data_req_t lsu_req;
   logic             lsu_ready;
   header_data_rsp_t lsu_rsp;
   logic             locked;
   logic [0:0]       owner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_req_arbiter #(.NUM_REQ(N)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .req_ready_o (ready),
      .rsp_o       (rsp),
      .lsu_req_o   (lsu_req),
      .lsu_ready_i (lsu_ready),
      .lsu_rsp_i   (lsu_rsp),
      .locked_o    (locked),
      .owner_o     (owner)
   );

   task automatic chk(input string nm, input logic [255:0] got,
                      input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // transaction-level model: is an op in flight, has it been sent,
   // who owns the lock, where round-robin resumes
   bit               m_busy, m_sent, m_lock;
   int               m_owner, m_ptr;
   header_data_req_t m_req;
   logic [N-1:0]     e_ready;
   header_data_req_t e_lsu;
   header_data_rsp_t e_rsp [N];

   function automatic int pick();
      int k;
      if (m_busy) return -1;
      if (m_lock) return m_owner;
      for (int o = 0; o < N; o++) begin
         k = (m_ptr + o) % N;
         if (req[k].val) return k;
      end
      return -1;
   endfunction

   initial begin
      int g;
      forever begin
         @(negedge clk);
         g = -1;
         e_ready = '0;
         e_lsu = '0;
         for (int k = 0; k < N; k++) e_rsp[k] = '0;
         if (!rst_n) begin
            m_busy = 0; m_sent = 0; m_lock = 0;
            m_owner = 0; m_ptr = 0; m_req = '0;
         end else begin
            g = pick();
            if (g >= 0) e_ready[g] = 1'b1;
            if (m_busy && !m_sent) begin
               e_lsu = m_req;
               e_lsu.val = 1'b1;
            end
            if (m_busy && m_sent && lsu_rsp.val) e_rsp[m_owner] = lsu_rsp;
         end
         chk("model ready", ready, e_ready);
         chk("model lsu_req", lsu_req, e_lsu);
         for (int k = 0; k < N; k++)
            chk($sformatf("model rsp[%0d]", k), rsp[k], e_rsp[k]);
         chk("model locked", locked, m_lock);
         chk("model owner", owner, m_owner);
         if (rst_n) begin
            if (g >= 0 && req[g].val) begin
               m_busy = 1; m_sent = 0;
               m_req = req[g]; m_owner = g;
            end else if (m_busy && !m_sent) begin
               if (lsu_ready) m_sent = 1;
            end else if (m_busy && m_sent && lsu_rsp.val) begin
               m_busy = 0;
               if (m_req.lsu_op == LSU_LOCK) m_lock = 1;
               else if (m_req.lsu_op == LSU_UNLOCK) m_lock = 0;
               if (!m_lock) m_ptr = (m_owner + 1) % N;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < N; k++) req[k] = '0;
      lsu_ready = 1'b0;
      lsu_rsp = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
   endtask

   function automatic header_data_req_t mk_req(input lsu_op_e op,
                                               input logic [63:0] a);
      header_data_req_t r;
      r = '0;
      r.val = 1'b1;
      r.lsu_op = op;
      r.addr = a;
      r.size = 64'h40;
      r.next_addr = a + 64'h40;
      r.tag = 28'h5a5;
      return r;
   endfunction

   // one full op: accept this cycle, issue next, respond the cycle after
   task automatic serve(input int who, input string nm);
      logic [63:0] a;
      logic [N-1:0] exp_r;
      a = req[who].addr;
      exp_r = '0;
      exp_r[who] = 1'b1;
      lsu_ready = 1'b1;
      settle();
      chk({nm, " ready"}, ready, exp_r);
      step();
      settle();
      chk({nm, " lsu val"}, lsu_req.val, 1'b1);
      chk({nm, " lsu addr"}, lsu_req.addr, a);
      step();
      lsu_rsp = '0;
      lsu_rsp.val = 1'b1;
      lsu_rsp.addr = 64'habc;
      settle();
      chk({nm, " rsp val"}, rsp[who].val, 1'b1);
      chk({nm, " rsp addr"}, rsp[who].addr, 64'habc);
      chk({nm, " rsp other"}, rsp[1 - who].val, 1'b0);
      step();
      lsu_rsp = '0;
      lsu_ready = 1'b0;
   endtask

   function automatic header_data_req_t rand_req();
      header_data_req_t r;
      r.val = 1'b1;
      r.lsu_op = lsu_op_e'(4'($urandom_range(0, 5)));
      r.addr = {$urandom, $urandom};
      r.size = {$urandom, $urandom};
      r.next_addr = {$urandom, $urandom};
      r.tag = 28'($urandom);
      return r;
   endfunction

   initial begin
      header_data_req_t r0;
      idle_inputs();
      do_reset();
      settle();
      chk("reset ready", ready, 2'b00);
      chk("reset locked", locked, 1'b0);
      chk("reset lsu val", lsu_req.val, 1'b0);
      step();

      // single LOAD from requester 0
      do_reset();
      req[0] = mk_req(LSU_LOAD, 64'h100);
      serve(0, "t1");
      idle_inputs();
      step();

      // both hammering: strict alternation from pointer 0
      do_reset();
      req[0] = mk_req(LSU_LOAD, 64'h110);
      req[1] = mk_req(LSU_LOAD, 64'h120);
      for (int i = 0; i < 4; i++) serve(i % 2, $sformatf("t2.%0d", i));
      idle_inputs();
      step();

      // lock sequence starves requester 1 until UNLOCK completes
      do_reset();
      req[1] = mk_req(LSU_LOAD, 64'h300);
      req[0] = mk_req(LSU_LOCK, 64'h200);
      serve(0, "t3 lock");
      settle();
      chk("t3 locked after lock", locked, 1'b1);
      req[0] = mk_req(LSU_LOAD, 64'h200);
      serve(0, "t3 load");
      req[0] = mk_req(LSU_INSERT, 64'h210);
      serve(0, "t3 insert");
      req[0] = mk_req(LSU_UNLOCK, 64'h200);
      serve(0, "t3 unlock");
      settle();
      chk("t3 locked after unlock", locked, 1'b0);
      serve(1, "t3 next");
      idle_inputs();
      step();

      // LSU back-pressure holds the request stable
      do_reset();
      r0 = mk_req(LSU_STORE, 64'h400);
      req[0] = r0;
      req[1] = mk_req(LSU_LOAD, 64'h500);
      settle();
      chk("t4 ready", ready, 2'b01);
      step();
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("t4 lsu_req hold", lsu_req, r0);
         chk("t4 ready stall", ready, 2'b00);
         step();
      end
      lsu_ready = 1'b1;
      step();
      lsu_rsp.val = 1'b1;
      step();
      idle_inputs();

      // stray response while idle; pointer now at 1
      lsu_rsp.val = 1'b1;
      lsu_rsp.addr = 64'hdead;
      settle();
      chk("t5 stray rsp0", rsp[0].val, 1'b0);
      chk("t5 stray rsp1", rsp[1].val, 1'b0);
      step();
      lsu_rsp = '0;
      req[1] = mk_req(LSU_LOAD, 64'h600);
      serve(1, "t5 after");
      idle_inputs();
      step();

      // reset while a LOCK waits for its response
      do_reset();
      req[0] = mk_req(LSU_LOCK, 64'h700);
      req[1] = mk_req(LSU_LOAD, 64'h710);
      lsu_ready = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      settle();
      chk("t6 rst ready", ready, 2'b00);
      chk("t6 rst lsu_req", lsu_req, '0);
      chk("t6 rst rsp0", rsp[0], '0);
      chk("t6 rst locked", locked, 1'b0);
      chk("t6 rst owner", owner, 1'b0);
      step();
      rst_n = 1'b1;
      settle();
      chk("t6 regrant", ready, 2'b01);
      step();

      // random traffic, model only
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < N; k++)
            req[k] = ($urandom % 4 != 0) ? rand_req() : '0;
         lsu_ready = 1'($urandom % 2);
         lsu_rsp.val = ($urandom % 3 == 0);
         lsu_rsp.addr = {$urandom, $urandom};
         lsu_rsp.size = {$urandom, $urandom};
         lsu_rsp.next_addr = {$urandom, $urandom};
         rst_n = ($urandom % 700 != 0);
         step();
      end
      rst_n = 1'b1;
      idle_inputs();
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
